// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES-128 key schedule and round datapath.
//   AES_KEY_W / AES_NR : AES-128 key width and round count
//   RCON               : round constants, indexed 1..10
//   key_state_e        : key-expander FSM states
//   xtime / gf_mul     : GF(2^8) arithmetic, modulus x^8+x^4+x^3+x+1
//   rcon_of            : range-safe RCON lookup (0 outside 1..10)
package aes_pkg;

   localparam int AES_KEY_W = 128;
   localparam int AES_NR    = 10;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRECOMP = 2'd1,
      STREAM  = 2'd2
   } key_state_e;

   // Multiply by x in GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add multiply in GF(2^8)
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? s : 8'h00);
         s = xtime(s);
      end
      return p;
   endfunction

   // Round constant lookup; indices outside 1..10 never occur in a valid step
   function automatic logic [7:0] rcon_of(input logic [3:0] idx);
      logic [7:0] v;
      if ((idx >= 4'd1) && (idx <= 4'd10)) begin
         v = RCON[idx];
      end else begin
         v = 8'h00;
      end
      return v;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box for one byte.
//   val : input byte
//   sub : substituted byte
// Computed as multiplicative inverse (x^254, which maps 0 to 0) followed by
// the AES affine transform, instead of a 256-entry table.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] val,
   output logic [7:0] sub
);

   // x^254 = x^(2+4+8+16+32+64+128): square repeatedly, accumulate each square
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(x, x);
      acc = sq;
      for (int i = 2; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // b ^ rotl1(b) ^ rotl2(b) ^ rotl3(b) ^ rotl4(b) ^ 0x63
   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   assign sub = affine(gf_inv(val));

endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule, one round key per beat.
//   i_clk, i_rst_n            : clock (rising edge), asynchronous active-low reset
//   i_key, i_key_valid, i_dir : cipher key, its valid, direction (1 = round 10..0)
//   o_key_ready               : high only while IDLE
//   o_rk, o_rk_round          : current round key and its round index
//   o_rk_valid, i_rk_ready    : round-key handshake
//   o_done                    : one-cycle pulse after the last key is accepted
// Build option AES_KEYEXP_REVERSE_EN: when defined, i_dir is honoured and the
// PRECOMP state plus inverse-step datapath are built; otherwise keys are always
// emitted forward and i_dir is ignored.
// Only one round key is stored; each next key is derived from the current one.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int KEY_W = AES_KEY_W,
   parameter int NR    = AES_NR
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [KEY_W-1:0] i_key,
   input  logic             i_key_valid,
   output logic             o_key_ready,
   input  logic             i_dir,
   output logic [KEY_W-1:0] o_rk,
   output logic [3:0]       o_rk_round,
   output logic             o_rk_valid,
   input  logic             i_rk_ready,
   output logic             o_done
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);
   localparam logic [3:0] PRE_LAST   = 4'(NR - 1);

   key_state_e       state_r, state_nxt_s;
   logic [KEY_W-1:0] key_r, key_nxt_s;
   logic [3:0]       round_r, round_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic             ready_r, ready_nxt_s;
   logic             done_r, done_nxt_s;

   logic [31:0]      w0_s, w1_s, w2_s, w3_s;
   logic [31:0]      sub_src_s, rot_s, sub_s, t_s;
   logic [3:0]       rcon_idx_s;
   logic [3:0]       next_round_s;
   logic             last_s;
   logic [KEY_W-1:0] fwd_key_s, step_key_s;

   assign {w0_s, w1_s, w2_s, w3_s} = key_r;

`ifdef AES_KEYEXP_REVERSE_EN
   logic             dir_r, dir_nxt_s;
   logic             inv_s;
   logic [KEY_W-1:0] inv_key_s;

   // Inverse steps only happen while streaming in reverse; PRECOMP runs forward
   assign inv_s        = dir_r & (state_r == STREAM);
   // Inverse step needs SubWord of the previous w3, which is w3' ^ w2'
   assign sub_src_s    = inv_s ? (w3_s ^ w2_s) : w3_s;
   assign rcon_idx_s   = inv_s ? round_r : (round_r + 4'd1);
   assign inv_key_s    = {w0_s ^ t_s, w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
   assign step_key_s   = inv_s ? inv_key_s : fwd_key_s;
   assign next_round_s = dir_r ? (round_r - 4'd1) : (round_r + 4'd1);
   assign last_s       = dir_r ? (round_r == 4'd0) : (round_r == LAST_ROUND);
`else
   logic dir_unused_s;

   assign dir_unused_s = i_dir;
   assign sub_src_s    = w3_s;
   assign rcon_idx_s   = round_r + 4'd1;
   assign step_key_s   = fwd_key_s;
   assign next_round_s = round_r + 4'd1;
   assign last_s       = (round_r == LAST_ROUND);
`endif

   // RotWord, then SubWord through four shared S-box instances
   assign rot_s = {sub_src_s[23:0], sub_src_s[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .val (rot_s[8*g +: 8]),
         .sub (sub_s[8*g +: 8])
      );
   end

   assign t_s = sub_s ^ {rcon_of(rcon_idx_s), 24'h000000};

   // Each forward word chains on the freshly computed word before it
   always_comb begin
      logic [31:0] n0, n1, n2, n3;
      n0 = w0_s ^ t_s;
      n1 = w1_s ^ n0;
      n2 = w2_s ^ n1;
      n3 = w3_s ^ n2;
      fwd_key_s = {n0, n1, n2, n3};
   end

   // Next-state and next-register values; every register holds by default
   always_comb begin
      state_nxt_s = state_r;
      key_nxt_s   = key_r;
      round_nxt_s = round_r;
      valid_nxt_s = valid_r;
      ready_nxt_s = ready_r;
      done_nxt_s  = 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
      dir_nxt_s   = dir_r;
`endif
      case (state_r)
         IDLE: begin
            if (i_key_valid && ready_r) begin
               key_nxt_s   = i_key;
               round_nxt_s = 4'd0;
               ready_nxt_s = 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
               dir_nxt_s   = i_dir;
               if (i_dir) begin
                  state_nxt_s = PRECOMP;
               end else begin
                  state_nxt_s = STREAM;
                  valid_nxt_s = 1'b1;
               end
`else
               state_nxt_s = STREAM;
               valid_nxt_s = 1'b1;
`endif
            end else begin
               ready_nxt_s = 1'b1;
            end
         end
`ifdef AES_KEYEXP_REVERSE_EN
         // round_r doubles as the step counter while walking up to round NR
         PRECOMP: begin
            key_nxt_s = step_key_s;
            if (round_r == PRE_LAST) begin
               round_nxt_s = LAST_ROUND;
               state_nxt_s = STREAM;
               valid_nxt_s = 1'b1;
            end else begin
               round_nxt_s = round_r + 4'd1;
            end
         end
`endif
         STREAM: begin
            if (i_rk_ready) begin
               if (last_s) begin
                  done_nxt_s  = 1'b1;
                  valid_nxt_s = 1'b0;
                  ready_nxt_s = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  key_nxt_s   = step_key_s;
                  round_nxt_s = next_round_s;
               end
            end else begin
               key_nxt_s   = key_r;
               round_nxt_s = round_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            ready_nxt_s = 1'b1;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Key, round index and registered handshake outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         key_r   <= '0;
         round_r <= 4'd0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
         dir_r   <= 1'b0;
`endif
      end else begin
         key_r   <= key_nxt_s;
         round_r <= round_nxt_s;
         valid_r <= valid_nxt_s;
         ready_r <= ready_nxt_s;
         done_r  <= done_nxt_s;
`ifdef AES_KEYEXP_REVERSE_EN
         dir_r   <= dir_nxt_s;
`endif
      end
   end

   assign o_rk        = key_r;
   assign o_rk_round  = round_r;
   assign o_rk_valid  = valid_r;
   assign o_key_ready = ready_r;
   assign o_done      = done_r;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed bench with a scoreboard queue for aes_key_expander.
// Expected round keys come from the published AES-128 schedule of
// 2b7e151628aed2a6abf7158809cf4f3c and from the all-zero key.
module tb_aes_key_expander;

   typedef struct packed {
      logic [127:0] rk;
      logic [3:0]   rnd;
      logic         chk;
   } exp_t;

`ifdef AES_KEYEXP_REVERSE_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   localparam logic [127:0] FIPS [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
   localparam logic [127:0] ZK1 = 128'h62636363626363636263636362636363;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] key;
   logic         key_valid;
   logic         key_ready;
   logic         dir;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready;
   logic         done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hs_cnt = 0, hs_cyc = 0;
   int done_cnt = 0, done_cyc = 0;
   int first_cyc = 0, last_beat_cyc = 0, sbeats = 0;
   exp_t exp_q[$];

   aes_key_expander dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_key       (key),
      .i_key_valid (key_valid),
      .o_key_ready (key_ready),
      .i_dir       (dir),
      .o_rk        (rk),
      .o_rk_round  (rk_round),
      .o_rk_valid  (rk_valid),
      .i_rk_ready  (rk_ready),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare each accepted beat with the head of the queue
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (key_valid && key_ready) begin
            hs_cnt++;
            hs_cyc = cyc;
            sbeats = 0;
         end
         if (rk_valid && rk_ready) begin
            if (sbeats == 0) first_cyc = cyc;
            last_beat_cyc = cyc;
            sbeats++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL extra_beat got_round=%0d expected=no_beat", rk_round);
            end else begin
               e = exp_q.pop_front();
               chk("beat_round", {124'h0, rk_round}, {124'h0, e.rnd});
               if (e.chk) chk("beat_key", rk, e.rk);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_stream(input bit zk, input bit d);
      exp_t e;
      bit   rev;
      int   r;
      rev = d && REV_EN;
      for (int i = 0; i < 11; i++) begin
         r     = rev ? (10 - i) : i;
         e.rnd = 4'(r);
         if (zk) begin
            e.rk  = (r == 1) ? ZK1 : 128'h0;
            e.chk = (r <= 1);
         end else begin
            e.rk  = FIPS[r];
            e.chk = 1'b1;
         end
         exp_q.push_back(e);
      end
   endtask

   // Offer a key (pushing its expected stream) and return once it is taken
   task automatic send_key(input bit zk, input bit d);
      int start;
      push_stream(zk, d);
      start     = hs_cnt;
      key       = zk ? 128'h0 : FIPS[0];
      dir       = d;
      key_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (hs_cnt != start) break;
      end
      key_valid = 1'b0;
      chk("key_taken", 128'(hs_cnt - start), 128'd1);
   endtask

   task automatic wait_done(input int target, input bit rnd);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done_cnt >= target) break;
      end
      rk_ready = 1'b1;
      chk("done_reached", 128'(done_cnt >= target), 128'd1);
   endtask

   initial begin
      bit found;
      rst_n     = 1'b0;
      key       = 128'h0;
      key_valid = 1'b0;
      dir       = 1'b0;
      rk_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rk", rk, 128'h0);
      chk("rst_round", {124'h0, rk_round}, 128'h0);
      chk("rst_valid", {127'h0, rk_valid}, 128'h0);
      chk("rst_done", {127'h0, done}, 128'h0);
      chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Case 1: forward, ready held high
      send_key(1'b0, 1'b0);
      wait_done(1, 1'b0);
      chk("c1_first_lat", 128'(first_cyc - hs_cyc), 128'd1);
      chk("c1_done_lat", 128'(done_cyc - hs_cyc), 128'd12);
      chk("c1_beats", 128'(sbeats), 128'd11);

      // Case 2 / 6: reverse request (forward when reverse is not built)
      send_key(1'b0, 1'b1);
      wait_done(2, 1'b0);
      chk("c2_first_lat", 128'(first_cyc - hs_cyc), REV_EN ? 128'd11 : 128'd1);
      chk("c2_done_after_last", 128'(done_cyc - last_beat_cyc), 128'd1);
      chk("c2_beats", 128'(sbeats), 128'd11);

      // Case 3: random back-pressure both directions
      send_key(1'b0, 1'b0);
      wait_done(3, 1'b1);
      chk("c3_fwd_beats", 128'(sbeats), 128'd11);
      send_key(1'b0, 1'b1);
      wait_done(4, 1'b1);
      chk("c3_rev_beats", 128'(sbeats), 128'd11);

      // Case 4: second key held valid mid-stream is taken only at o_done
      send_key(1'b0, 1'b0);
      send_key(1'b1, 1'b0);
      chk("c4_hs_at_done", 128'(hs_cyc), 128'(done_cyc));
      chk("c4_done_cnt", 128'(done_cnt), 128'd5);
      wait_done(6, 1'b0);

      // Case 5: asynchronous reset at round 5, then the all-zero key
      send_key(1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rk_valid && rk_round == 4'd5) begin
            found = 1'b1;
            break;
         end
      end
      chk("c5_round5_seen", {127'h0, found}, 128'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("c5_rst_rk", rk, 128'h0);
      chk("c5_rst_round", {124'h0, rk_round}, 128'h0);
      chk("c5_rst_valid", {127'h0, rk_valid}, 128'h0);
      chk("c5_rst_key_ready", {127'h0, key_ready}, 128'h1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("c5_idle_no_valid", {127'h0, rk_valid}, 128'h0);
      chk("c5_no_done", 128'(done_cnt), 128'd6);
      send_key(1'b1, 1'b0);
      wait_done(7, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
